// File: rtl/fsm_stream_checker.sv
// Receive-side checker for a 4-bit state stream: flags illegal arcs, bad states and stutters,
// keeps saturating counters and sticky visit/arc coverage maps. Optional macro: FSM_CHK_HALT_EN.
module fsm_stream_checker #(
    parameter int ERR_W = 16,
    parameter int TRN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       state,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [3:0]       err_from,
    output logic [3:0]       err_to,
    output logic [ERR_W-1:0] err_cnt,
    output logic [TRN_W-1:0] trn_cnt,
    output logic [15:0]      visit_map,
    output logic [17:0]      arc_cov,
    output logic             cov_full
`ifdef FSM_CHK_HALT_EN
    ,
    output logic             halt
`endif
);

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ARC     = 2'd1,
        ERR_BAD     = 2'd2,
        ERR_STUTTER = 2'd3
    } err_code_e;

    logic [3:0]  prv;
    logic        prv_vld;
    logic [17:0] arc_hit;
    err_code_e   chk_code;

    function automatic logic is_bad(input logic [3:0] s);
        return (s inside {4'd10, 4'd11, 4'd12, 4'd13, 4'd15});
    endfunction

    // One-hot arc_cov index of a legal (prv, state) pair; zero for anything else.
    function automatic logic [17:0] arc_lookup(input logic [3:0] p, input logic [3:0] s);
        logic [17:0] hit;
        hit = '0;
        case ({p, s})
            8'h01: hit[0]  = 1'b1;
            8'h12: hit[1]  = 1'b1;
            8'h14: hit[2]  = 1'b1;
            8'h23: hit[3]  = 1'b1;
            8'h35: hit[4]  = 1'b1;
            8'h31: hit[5]  = 1'b1;
            8'h45: hit[6]  = 1'b1;
            8'h51: hit[7]  = 1'b1;
            8'h56: hit[8]  = 1'b1;
            8'h67: hit[9]  = 1'b1;
            8'h70: hit[10] = 1'b1;
            8'h78: hit[11] = 1'b1;
            8'h82: hit[12] = 1'b1;
            8'h84: hit[13] = 1'b1;
            8'h8E: hit[14] = 1'b1;
            8'h89: hit[15] = 1'b1;
            8'h90: hit[16] = 1'b1;
            8'hE0: hit[17] = 1'b1;
            default: hit = '0;
        endcase
        return hit;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        chk_code = ERR_NONE;
        arc_hit  = arc_lookup(prv, state);
        if (is_bad(state))
            chk_code = ERR_BAD;
        else if (state == prv)
            chk_code = ERR_STUTTER;
        else if (!is_bad(prv) && (arc_hit == '0))
            chk_code = ERR_ARC;
        else if (is_bad(prv) && (state != 4'd4))
            chk_code = ERR_ARC;
    end

    assign cov_full = &arc_cov;

    // NOTE: all state here is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prv       <= '0;
            prv_vld   <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            err_from  <= '0;
            err_to    <= '0;
            err_cnt   <= '0;
            trn_cnt   <= '0;
            visit_map <= '0;
            arc_cov   <= '0;
`ifdef FSM_CHK_HALT_EN
            halt      <= 1'b0;
`endif
        end else begin
            err              <= 1'b0;
            prv              <= state;
            prv_vld          <= 1'b1;
            visit_map[state] <= 1'b1;
            if (prv_vld) begin
                if (trn_cnt != '1)
                    trn_cnt <= trn_cnt + TRN_W'(1);
                if (chk_code == ERR_NONE) begin
                    arc_cov <= arc_cov | arc_hit;
                end else begin
                    err <= 1'b1;
                    if (err_cnt != '1)
                        err_cnt <= err_cnt + ERR_W'(1);
`ifdef FSM_CHK_HALT_EN
                    // Only the first error after reset is captured; later ones just count.
                    if (!halt) begin
                        err_code <= chk_code;
                        err_from <= prv;
                        err_to   <= state;
                    end
                    halt <= 1'b1;
`else
                    err_code <= chk_code;
                    err_from <= prv;
                    err_to   <= state;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_fsm_stream_checker.sv
// Self-checking bench for fsm_stream_checker: table-driven streams scored through a queue,
// plus hand-written end-of-stream and mid-run reset checks.
module tb_fsm_stream_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  state;
    logic        err;
    logic [1:0]  err_code;
    logic [3:0]  err_from;
    logic [3:0]  err_to;
    logic [15:0] err_cnt;
    logic [15:0] trn_cnt;
    logic [15:0] visit_map;
    logic [17:0] arc_cov;
    logic        cov_full;
`ifdef FSM_CHK_HALT_EN
    logic        halt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] st;
        logic       e;
        logic [1:0] code;
    } vec_t;

    typedef struct {
        logic       e;
        logic [1:0] code;
        logic [3:0] from;
        logic [3:0] to;
    } exp_t;

    vec_t       tbl[$];
    exp_t       sb[$];
    logic [3:0] last_st;
    logic       tb_halted;

    always #5 clk = ~clk;

    fsm_stream_checker #(.ERR_W(16), .TRN_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .state     (state),
        .err       (err),
        .err_code  (err_code),
        .err_from  (err_from),
        .err_to    (err_to),
        .err_cnt   (err_cnt),
        .trn_cnt   (trn_cnt),
        .visit_map (visit_map),
        .arc_cov   (arc_cov),
        .cov_full  (cov_full)
`ifdef FSM_CHK_HALT_EN
        ,
        .halt      (halt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] st, input logic e, input logic [1:0] code);
        vec_t v;
        v.st = st; v.e = e; v.code = code;
        tbl.push_back(v);
    endtask

    // Starts and ends on a falling edge; drives one sample and scores the registered result.
    task automatic step(input vec_t v);
        exp_t x, got;
        state = v.st;
        x.e = v.e; x.code = v.code; x.from = last_st; x.to = v.st;
        sb.push_back(x);
        last_st = v.st;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check("err", {31'd0, err}, {31'd0, got.e});
            if (got.e && !tb_halted) begin
                check("err_code", {30'd0, err_code}, {30'd0, got.code});
                check("err_from", {28'd0, err_from}, {28'd0, got.from});
                check("err_to",   {28'd0, err_to},   {28'd0, got.to});
            end
`ifdef FSM_CHK_HALT_EN
            if (got.e) tb_halted = 1'b1;
            check("halt", {31'd0, halt}, {31'd0, tb_halted});
`endif
        end
        @(negedge clk);
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) step(tbl[i]);
        tbl.delete();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_err"},       {31'd0, err},       32'd0);
        check({tag, "_err_code"},  {30'd0, err_code},  32'd0);
        check({tag, "_err_from"},  {28'd0, err_from},  32'd0);
        check({tag, "_err_to"},    {28'd0, err_to},    32'd0);
        check({tag, "_err_cnt"},   {16'd0, err_cnt},   32'd0);
        check({tag, "_trn_cnt"},   {16'd0, trn_cnt},   32'd0);
        check({tag, "_visit_map"}, {16'd0, visit_map}, 32'd0);
        check({tag, "_arc_cov"},   {14'd0, arc_cov},   32'd0);
        check({tag, "_cov_full"},  {31'd0, cov_full},  32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        state = 4'd0;
        @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;
        last_st = 4'd0;
        tb_halted = 1'b0;
    endtask

    initial begin
        logic [3:0] walk[$];
        rst = 1'b1;
        state = 4'd0;
        last_st = 4'd0;
        tb_halted = 1'b0;
        repeat (2) @(posedge clk);

        // Legal stream, no errors.
        do_reset();
        add(0,0,0); add(1,0,0); add(2,0,0); add(3,0,0);
        add(5,0,0); add(6,0,0); add(7,0,0); add(0,0,0);
        run_tbl();
        check("a_trn_cnt",   {16'd0, trn_cnt},   32'd7);
        check("a_err_cnt",   {16'd0, err_cnt},   32'd0);
        check("a_arc_cov",   {14'd0, arc_cov},   32'h0071B);
        check("a_visit_map", {16'd0, visit_map}, 32'h00EF);
        check("a_cov_full",  {31'd0, cov_full},  32'd0);

        // Illegal arc 1->3, then a legal 3->5 shows err was a single pulse.
        do_reset();
        add(0,0,0); add(1,0,0); add(3,1,1); add(5,0,0);
        run_tbl();
        check("b_err_cnt",  {16'd0, err_cnt},  32'd1);
        check("b_err_code", {30'd0, err_code}, 32'd1);
        check("b_err_from", {28'd0, err_from}, 32'd1);
        check("b_err_to",   {28'd0, err_to},   32'd3);

        // Bad state then recovery through 4.
        do_reset();
        add(8,0,0); add(14,0,0); add(15,1,2); add(4,0,0); add(5,0,0);
        run_tbl();
        check("c_err_cnt", {16'd0, err_cnt}, 32'd1);
        check("c_arc_cov", {14'd0, arc_cov}, 32'h04040);
        check("c_trn_cnt", {16'd0, trn_cnt}, 32'd4);
        check("c_err_from", {28'd0, err_from}, 32'd14);

        // Stutter, then back-to-back bad states (bad-to-bad is one code-2 error).
        do_reset();
        add(5,0,0); add(5,1,3); add(6,0,0); add(7,0,0); add(8,0,0);
        add(10,1,2); add(11,1,2); add(4,0,0); add(5,0,0);
        run_tbl();
        check("d_err_cnt",   {16'd0, err_cnt},   32'd3);
        check("d_visit_map", {16'd0, visit_map}, 32'h0DF0);

        // Walk every legal arc.
        do_reset();
        walk = '{0,1,2,3,1,4,5,1,2,3,5,6,7,8,2,3,5,6,7,8,4,5,6,7,8,14,0,
                 1,2,3,5,6,7,8,9,0,1,2,3,5,6,7,0};
        foreach (walk[i]) add(walk[i], 1'b0, 2'd0);
        run_tbl();
        check("e_arc_cov",   {14'd0, arc_cov},   32'h3FFFF);
        check("e_cov_full",  {31'd0, cov_full},  32'd1);
        check("e_err_cnt",   {16'd0, err_cnt},   32'd0);
        check("e_visit_map", {16'd0, visit_map}, 32'h43FF);
        check("e_trn_cnt",   {16'd0, trn_cnt},   32'(walk.size() - 1));

        // Mid-run reset clears everything without waiting for a clock edge.
        rst = 1'b1;
        #1;
        check_cleared("midrst");
        @(negedge clk);
        rst = 1'b0;
        last_st = 4'd0;
        tb_halted = 1'b0;
        add(1,0,0); add(2,0,0);
        run_tbl();
        check("f_trn_cnt", {16'd0, trn_cnt}, 32'd1);
        check("f_arc_cov", {14'd0, arc_cov}, 32'h00002);

`ifdef FSM_CHK_HALT_EN
        // First error is frozen; later errors still pulse and count.
        do_reset();
        add(0,0,0); add(2,1,1); add(3,0,0); add(1,0,0); add(4,0,0); add(6,1,1);
        run_tbl();
        check("h_err_from", {28'd0, err_from}, 32'd0);
        check("h_err_to",   {28'd0, err_to},   32'd2);
        check("h_err_cnt",  {16'd0, err_cnt},  32'd2);
        check("h_halt",     {31'd0, halt},     32'd1);
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
